// File: rtl/regfile_dump_engine.sv
// Debug reader that walks the architectural register file through a dedicated
// read port and streams (index, data) beats out on a valid/ready interface.
module regfile_dump_engine #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                abort_pend_q, abort_pend_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_index_q, out_index_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  // NOTE: every signal written here gets a default first, otherwise any path
  // that skips an assignment infers a latch.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    abort_pend_d = abort_pend_q;
    out_valid_d  = out_valid_q;
    out_index_d  = out_index_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (abort || abort_pend_q) begin
          state_d = S_DONE;
        end else begin
          // x0 is hardwired to zero whatever the read port returns.
          out_data_d  = (idx_q == '0) ? '0 : rd_data;
          out_index_d = idx_q;
          out_last_d  = (idx_q == LAST_IDX);
          out_valid_d = 1'b1;
          state_d     = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (abort_pend_q || abort || out_last_q) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end else if (abort) begin
          // The pending beat must still be delivered; remember the abort.
          abort_pend_d = 1'b1;
        end
      end
      S_DONE: begin
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      abort_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      abort_pend_q <= abort_pend_d;
      out_valid_q  <= out_valid_d;
      out_index_q  <= out_index_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  assign busy      = (state_q == S_READ) || (state_q == S_SEND);
  assign done      = (state_q == S_DONE);
  assign rd_addr   = (state_q == S_READ) ? idx_q : '0;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_regfile_dump_engine.sv
// Scoreboard bench for regfile_dump_engine: directed dumps push expected beats,
// a negedge monitor pops and compares each delivered beat.
module tb_regfile_dump_engine;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef struct {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              busy, done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  logic [DATA_W-1:0] rf [NUM_REGS];
  beat_t             exp_q [$];
  int                checks = 0;
  int                errors = 0;
  int                stray_start_at = -1;
  int                wr_a_at = -1;
  int                wr_b_at = -1;

  assign rd_data = rf[rd_addr];

  always #5 clk = ~clk;

  regfile_dump_engine #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .out_data(out_data), .out_last(out_last)
  );

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input int i, input logic [DATA_W-1:0] d);
    beat_t b;
    b.idx  = ADDR_W'(i);
    b.data = d;
    b.last = (i == NUM_REGS - 1);
    exp_q.push_back(b);
  endtask

  // Fresh register file holds reg[i] = i, so beat i carries i (beat 0 is 0).
  task automatic push_identity(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push_beat(i, DATA_W'(i));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after the start edge until done is seen; applies optional hooks.
  task automatic run_to_done(output int n);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      n++;
      start = (n == stray_start_at);
      if (n == wr_a_at) rf[20] = 32'hA5A5_A5A5;
      if (n == wr_b_at) rf[2]  = 32'h1234_5678;
      if (done) break;
    end
    start = 1'b0;
    check("done_seen", done, 1);
  endtask

  task automatic wait_beat(input int k, input string name);
    for (int c = 0; c < 200; c++) begin
      if (out_valid && out_index == ADDR_W'(k)) break;
      @(posedge clk);
      #1;
    end
    check(name, out_valid && out_index == ADDR_W'(k), 1);
  endtask

  // Monitor: a beat transfers on the next rising edge when valid && ready here.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_index", out_index, e.idx);
        check("beat_data",  out_data,  e.data);
        check("beat_last",  out_last,  e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(i);

    // Reset state while reset is held.
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_index", out_index, 0);
    check("rst_data", out_data, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Full dump with x0 masking and a stray start at beat 10.
    rf[0] = 32'hDEAD_BEEF;
    push_identity(0, NUM_REGS - 1);
    stray_start_at = 20;
    pulse_start();
    run_to_done(n);
    stray_start_at = -1;
    check("full_done_edge", n, 64);
    @(posedge clk);
    #1;
    check("full_busy_after", busy, 0);
    check("full_done_once", done, 0);
    check("full_drained", exp_q.size(), 0);
    rf[0] = '0;

    // Backpressure on beat 3.
    push_identity(0, NUM_REGS - 1);
    pulse_start();
    wait_beat(3, "bp_reach_beat3");
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_index", out_index, 3);
      check("bp_hold_data", out_data, 3);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_valid_drop", out_valid, 0);
    @(posedge clk);
    #1;
    check("bp_beat4_valid", out_valid, 1);
    check("bp_beat4_index", out_index, 4);
    run_to_done(n);
    @(posedge clk);
    #1;
    check("bp_drained", exp_q.size(), 0);

    // Abort while beat 7 is pending.
    push_identity(0, 7);
    pulse_start();
    wait_beat(7, "ab_reach_beat7");
    out_ready = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("ab_hold_valid", out_valid, 1);
    check("ab_hold_index", out_index, 7);
    @(posedge clk);
    #1;
    check("ab_hold_valid2", out_valid, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("ab_valid_drop", out_valid, 0);
    check("ab_done", done, 1);
    @(posedge clk);
    #1;
    check("ab_done_pulse", done, 0);
    check("ab_busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("ab_drained", exp_q.size(), 0);
    push_identity(0, NUM_REGS - 1);
    pulse_start();
    run_to_done(n);
    check("ab_restart_edge", n, 64);

    // Asynchronous reset at beat 12.
    @(posedge clk);
    #1;
    push_identity(0, 11);
    pulse_start();
    wait_beat(12, "rst_reach_beat12");
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("mid_rst_no_done", done, 0);
    end
    reset = 1'b0;
    check("mid_rst_drained", exp_q.size(), 0);
    push_identity(0, NUM_REGS - 1);
    pulse_start();
    run_to_done(n);
    check("mid_rst_restart_edge", n, 64);

    // Datapath writes during a dump: reg[20] before its read, reg[2] after.
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REGS; i++)
      push_beat(i, (i == 20) ? 32'hA5A5_A5A5 : DATA_W'(i));
    wr_a_at = 11;
    wr_b_at = 19;
    pulse_start();
    run_to_done(n);
    wr_a_at = -1;
    wr_b_at = -1;
    check("wr_done_edge", n, 64);

    repeat (3) @(posedge clk);
    #1;
    check("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
